// File: rtl/instr_sequencer.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// issuing datapath strobes, guarding memory waits with a timeout, counting retirements.
module instr_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt_req,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             data_read,
  input  logic             data_write,
  input  logic             reg_write,
  input  logic [2:0]       branch_type,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_src,
  output logic             dmem_rd,
  output logic             dmem_wr,
  output logic             rf_we,
  output logic             busy,
  output logic             bus_error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERROR  = 3'd6
  } state_t;

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_t            cur, nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              op_rd, op_wr;
  logic              retire;
  logic              timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      wait_cnt <= '0;
      op_rd    <= 1'b0;
      op_wr    <= 1'b0;
      retired  <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      // Decode is only valid in EXEC; hold it for the MEM phase.
      if (cur == EXEC) begin
        op_rd <= data_read;
        op_wr <= data_write;
      end
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt      = cur;
    wait_nxt = '0;
    ir_load  = 1'b0;
    pc_load  = 1'b0;
    pc_src   = 1'b0;
    retire   = 1'b0;
    case (cur)
      IDLE:   if (run) nxt = FETCH;
      FETCH: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          nxt     = DECODE;
        end else if (timeout_hit) begin
          nxt = ERROR;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      DECODE: nxt = EXEC;
      EXEC: begin
        if (data_read && data_write)      nxt = ERROR;
        else if (data_read || data_write) nxt = MEM;
        else if (reg_write)               nxt = WB;
        else begin
          retire = 1'b1;
          pc_src = (branch_type != 3'd0) && branch_taken;
        end
      end
      MEM: begin
        if (dmem_ack) begin
          if (op_rd) nxt = WB;
          else       retire = 1'b1;
        end else if (timeout_hit) begin
          nxt = ERROR;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      WB:      retire = 1'b1;
      ERROR:   nxt = ERROR;
      default: nxt = ERROR;
    endcase
    if (retire) begin
      pc_load = 1'b1;
      nxt     = (run && !halt_req) ? FETCH : IDLE;
    end
  end

  always_comb begin
    imem_req  = (cur == FETCH);
    dmem_rd   = (cur == MEM) && op_rd;
    dmem_wr   = (cur == MEM) && op_wr;
    rf_we     = (cur == WB);
    busy      = (cur != IDLE) && (cur != ERROR);
    bus_error = (cur == ERROR);
    state     = cur;
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: hand-derived expectations for each cycle of
// ALU, load, branch, store/halt, timeout, reset-abort and counter-wrap scenarios.
module tb_instr_sequencer;

  logic       clk, reset, run, halt_req, imem_ack, dmem_ack;
  logic       data_read, data_write, reg_write, branch_taken;
  logic [2:0] branch_type;
  logic       imem_req, ir_load, pc_load, pc_src, dmem_rd, dmem_wr, rf_we, busy, bus_error;
  logic [2:0] state;
  logic [3:0] retired;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .halt_req(halt_req),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .data_read(data_read), .data_write(data_write), .reg_write(reg_write),
    .branch_type(branch_type), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .rf_we(rf_we), .busy(busy),
    .bus_error(bus_error), .state(state), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    run = 0; halt_req = 0; imem_ack = 0; dmem_ack = 0;
    data_read = 0; data_write = 0; reg_write = 0;
    branch_type = 3'd0; branch_taken = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    clear_inputs();
    step();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_retired", retired, 0);
    chk("rst_bus_error", bus_error, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_pc_load", pc_load, 0);

    // ALU instructions back to back
    reset = 0; run = 1; imem_ack = 1; reg_write = 1;
    #1;
    chk("alu_idle", state, 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk("alu_fetch", state, 1); chk("alu_ir_load", ir_load, 1); chk("alu_imem_req", imem_req, 1);
      step(); chk("alu_decode", state, 2); chk("alu_dec_ir_load", ir_load, 0);
      step(); chk("alu_exec", state, 3); chk("alu_exec_pc_load", pc_load, 0);
      step(); chk("alu_wb", state, 5); chk("alu_rf_we", rf_we, 1);
      chk("alu_pc_load", pc_load, 1); chk("alu_pc_src", pc_src, 0);
    end
    step(); chk("alu_next_fetch", state, 1); chk("alu_retired", retired, 3);
    do_reset();

    // Load with dmem_ack two cycles late
    run = 1; imem_ack = 1; reg_write = 1; data_read = 1;
    #1;
    step(); chk("ld_fetch", state, 1);
    step(); chk("ld_decode", state, 2);
    step(); chk("ld_exec", state, 3); chk("ld_exec_dmem_rd", dmem_rd, 0);
    step(); chk("ld_mem1", state, 4); chk("ld_mem1_rd", dmem_rd, 1); chk("ld_mem1_wr", dmem_wr, 0);
    data_read = 0; reg_write = 0;
    #1;
    chk("ld_mem1_rd_held", dmem_rd, 1);
    step(); chk("ld_mem2", state, 4); chk("ld_mem2_rd", dmem_rd, 1);
    step(); dmem_ack = 1; #1;
    chk("ld_mem3", state, 4); chk("ld_mem3_rd", dmem_rd, 1); chk("ld_mem3_pc_load", pc_load, 0);
    step(); dmem_ack = 0;
    chk("ld_wb", state, 5); chk("ld_rf_we", rf_we, 1); chk("ld_pc_load", pc_load, 1);
    step(); chk("ld_next_fetch", state, 1); chk("ld_rf_we_off", rf_we, 0); chk("ld_retired", retired, 1);
    do_reset();

    // Branch taken then not taken
    run = 1; imem_ack = 1; branch_type = 3'b001; branch_taken = 1;
    #1;
    step(); chk("br_fetch", state, 1);
    step(); chk("br_decode", state, 2);
    step(); chk("br_exec", state, 3); chk("br_t_pc_load", pc_load, 1); chk("br_t_pc_src", pc_src, 1);
    step(); chk("br_fetch2", state, 1);
    branch_taken = 0;
    step(); chk("br_decode2", state, 2);
    step(); chk("br_nt_pc_load", pc_load, 1); chk("br_nt_pc_src", pc_src, 0);
    step(); chk("br_fetch3", state, 1); chk("br_retired", retired, 2);
    do_reset();

    // Read and write together is illegal
    run = 1; imem_ack = 1; data_read = 1; data_write = 1;
    #1;
    step(); step(); step();
    chk("rw_exec", state, 3);
    step(); chk("rw_error", state, 6); chk("rw_bus_error", bus_error, 1);
    chk("rw_dmem_rd", dmem_rd, 0); chk("rw_dmem_wr", dmem_wr, 0);
    do_reset();

    // Fetch timeout
    run = 1; imem_ack = 0;
    #1;
    for (int i = 0; i < 15; i++) begin
      step(); chk("to_fetch", state, 1);
    end
    step(); chk("to_error", state, 6); chk("to_bus_error", bus_error, 1);
    chk("to_busy", busy, 0); chk("to_imem_req", imem_req, 0);
    run = 0; step(); run = 1; step(); step();
    chk("to_sticky", state, 6); chk("to_sticky_err", bus_error, 1);
    reset = 1; #1;
    chk("to_reset_state", state, 0); chk("to_reset_err", bus_error, 0);
    clear_inputs();
    step(); reset = 0;

    // Store with halt during MEM, ack on the last allowed wait cycle
    run = 1; imem_ack = 1; data_write = 1;
    #1;
    step(); step(); step();
    chk("st_exec", state, 3);
    step(); chk("st_mem1", state, 4); chk("st_dmem_wr", dmem_wr, 1); chk("st_dmem_rd", dmem_rd, 0);
    halt_req = 1;
    repeat (13) step();
    chk("st_mem14", state, 4);
    step(); dmem_ack = 1; #1;
    chk("st_mem15", state, 4); chk("st_pc_load", pc_load, 1); chk("st_pc_src", pc_src, 0);
    step(); dmem_ack = 0;
    chk("st_idle", state, 0); chk("st_retired", retired, 1); chk("st_busy", busy, 0);

    // Reset during WB aborts without pulses
    halt_req = 0; data_write = 0; reg_write = 1;
    #1;
    step(); chk("rw_fetch", state, 1);
    step(); step();
    step(); chk("rwb_wb", state, 5); chk("rwb_rf_we", rf_we, 1);
    reset = 1; #1;
    chk("rwb_state", state, 0); chk("rwb_rf_we_off", rf_we, 0); chk("rwb_pc_load", pc_load, 0);
    chk("rwb_retired", retired, 0); chk("rwb_busy", busy, 0);
    clear_inputs();
    step(); reset = 0;

    // Counter wrap with 4-bit width
    run = 1; imem_ack = 1;
    #1;
    for (int i = 0; i < 17; i++) begin
      step(); chk("wr_fetch", state, 1); chk("wr_count", retired, i % 16);
      step();
      step(); chk("wr_pc_load", pc_load, 1); chk("wr_pc_src", pc_src, 0);
    end
    step(); chk("wr_final_state", state, 1); chk("wr_wrapped", retired, 1);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
